// File: rtl/pwm_ctrl_pkg.sv
// Shared types and arithmetic helpers for the PWM duty-ramp controller.
// Build option PWM_FAULT_EN (in the top) enables the FAULT state; the enum always reserves it.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        FAULT     = 2'd3
    } state_t;

    function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
        return (duty > period) ? period : duty;
    endfunction

    // Moves cur toward tgt by at most step; the result never passes tgt and never wraps.
    function automatic int unsigned step_toward(input int unsigned cur, input int unsigned tgt,
                                                input int unsigned step);
        if (tgt >= cur) begin
            return ((tgt - cur) <= step) ? tgt : cur + step;
        end
        return ((cur - tgt) <= step) ? tgt : cur - step;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..PERIOD-1, flags the first tick (period_start)
// and the last tick (boundary), where the owner may update the duty.
module pwm_period_counter #(
    parameter int PERIOD = 10,
    parameter int W      = $clog2(PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic         period_start,
    output logic         boundary
);

    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign period_start = (cnt == '0);
    assign boundary     = (cnt == LAST);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// PWM sequencer: accepts target-duty commands and ramps the applied duty by STEP per period.
// Define PWM_FAULT_EN to add the fault/fault_clr inputs and the latched FAULT state.
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD     = 10,
    parameter int DUTY_W     = $clog2(PERIOD + 1),
    parameter int STEP       = 1,
    parameter int RESET_DUTY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic [DUTY_W-1:0] cnt_out,
    output logic [DUTY_W-1:0] duty_out,
    output logic              period_start,
    output logic              busy,
    output logic              done,
`ifdef PWM_FAULT_EN
    input  logic              fault,
    input  logic              fault_clr,
`endif
    output state_t            state
);

    // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
    // cmd_valid/cmd_duty need not be held afterwards and cmd_ready never depends on cmd_valid.

    localparam logic [DUTY_W-1:0] RST_DUTY = DUTY_W'(RESET_DUTY);

    logic              boundary;
    logic              accept;
    logic              done_nxt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    state_t            state_nxt;

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .W      (DUTY_W)
    ) u_period_counter (
        .clk          (clk),
        .rst          (rst),
        .cnt          (cnt_out),
        .period_start (period_start),
        .boundary     (boundary)
    );

`ifdef PWM_FAULT_EN
    assign cmd_ready = (state != FAULT);
`else
    assign cmd_ready = 1'b1;
`endif

    assign accept = cmd_valid && cmd_ready;
    assign busy   = (state == RAMP_UP) || (state == RAMP_DOWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The boundary step reads the registered target, so a command landing on the
    // same edge only takes effect from the following boundary.
    always_comb begin
        target_nxt = target;
        duty_nxt   = duty_out;
        state_nxt  = state;
        done_nxt   = 1'b0;
        if (accept) begin
            target_nxt = DUTY_W'(clamp_duty(32'(cmd_duty), PERIOD));
        end
        if (boundary) begin
            duty_nxt = DUTY_W'(step_toward(32'(duty_out), 32'(target), STEP));
        end
        // State follows the post-edge relation, so busy tracks duty_out != target exactly.
        if (target_nxt > duty_nxt) begin
            state_nxt = RAMP_UP;
        end else if (target_nxt < duty_nxt) begin
            state_nxt = RAMP_DOWN;
        end else begin
            state_nxt = IDLE;
        end
`ifdef PWM_FAULT_EN
        if (state == FAULT) begin
            target_nxt = target;
            duty_nxt   = duty_out;
            state_nxt  = fault_clr ? IDLE : FAULT;
        end
        if (fault) begin
            target_nxt = '0;
            duty_nxt   = '0;
            state_nxt  = FAULT;
        end
`endif
        done_nxt = busy && (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target   <= RST_DUTY;
            duty_out <= RST_DUTY;
            done     <= 1'b0;
        end else begin
            target   <= target_nxt;
            duty_out <= duty_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl (PERIOD=10, STEP=1, RESET_DUTY=5);
// the fault section is built only when PWM_FAULT_EN is defined.
module tb_pwm_duty_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int PERIOD = 10;
    localparam int W      = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [W-1:0] cmd_duty = '0;
    logic         cmd_ready;
    logic [W-1:0] cnt_out;
    logic [W-1:0] duty_out;
    logic         period_start;
    logic         busy;
    logic         done;
    state_t       state;
`ifdef PWM_FAULT_EN
    logic         fault = 1'b0;
    logic         fault_clr = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // exp_q holds {busy, duty} expected at each period start; done_q the duty at each done pulse.
    logic [W:0]   exp_q[$];
    logic [W-1:0] done_q[$];
    logic [W:0]   e;
    logic [W-1:0] de;

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl #(
        .PERIOD     (PERIOD),
        .DUTY_W     (W),
        .STEP       (1),
        .RESET_DUTY (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_duty     (cmd_duty),
        .cnt_out      (cnt_out),
        .duty_out     (duty_out),
        .period_start (period_start),
        .busy         (busy),
        .done         (done),
`ifdef PWM_FAULT_EN
        .fault        (fault),
        .fault_clr    (fault_clr),
`endif
        .state        (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mon_en && period_start) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_period: got duty %0d, expected no unchecked period", duty_out);
                end else begin
                    e = exp_q.pop_front();
                    check("duty_at_start", 32'(duty_out), 32'(e[W-1:0]));
                    check("busy_at_start", 32'(busy), 32'(e[W]));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at duty %0d, expected no pulse", duty_out);
                end else begin
                    de = done_q.pop_front();
                    check("duty_at_done", 32'(duty_out), 32'(de));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until cnt_out == c; a pending command is dropped after its accepting edge.
    task automatic to_cnt(input int c, output int edges);
        edges = 0;
        do begin
            tick();
            cmd_valid = 1'b0;
            edges++;
        end while ((32'(cnt_out) != c) && (edges < 100));
    endtask

    task automatic send(input int d);
        check("cmd_ready", 32'(cmd_ready), 1);
        cmd_duty  = d[W-1:0];
        cmd_valid = 1'b1;
    endtask

    task automatic run_period(input int d, input int b, input int dn);
        int n;
        exp_q.push_back({b[0], d[W-1:0]});
        if (dn != 0) done_q.push_back(d[W-1:0]);
        to_cnt(0, n);
        check("period_len", n, PERIOD);
    endtask

    task automatic check_reset_state();
        check("rst_cnt", 32'(cnt_out), 0);
        check("rst_duty", 32'(duty_out), 5);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_state", 32'(state), 32'(IDLE));
    endtask

    initial begin
        int n;
        // Reset and free-running counter
        tick();
        tick();
        check_reset_state();
        mon_en = 1'b1;
        exp_q.push_back({1'b0, 4'd5});
        rst = 1'b0;
        run_period(5, 0, 0);
        run_period(5, 0, 0);

        // Ramp up 5 -> 8
        send(8);
        run_period(6, 1, 0);
        run_period(7, 1, 0);
        run_period(8, 0, 1);

        // Ramp down 8 -> 5, then retarget mid-ramp 5 -> 8 at duty 6 to 2
        send(5);
        run_period(7, 1, 0);
        run_period(6, 1, 0);
        run_period(5, 0, 1);
        send(8);
        run_period(6, 1, 0);
        send(2);
        run_period(5, 1, 0);
        run_period(4, 1, 0);
        run_period(3, 1, 0);
        run_period(2, 0, 1);

        // Over-range command clamps to PERIOD, then full ramp to 0
        send(15);
        for (int d = 3; d <= 10; d++) run_period(d, (d != 10) ? 1 : 0, (d == 10) ? 1 : 0);
        send(0);
        for (int d = 9; d >= 0; d--) run_period(d, (d != 0) ? 1 : 0, (d == 0) ? 1 : 0);

        // Command equal to current duty in IDLE: no ramp, no done
        send(0);
        run_period(0, 0, 0);

        // Command accepted on the boundary edge: that boundary keeps the old target
        to_cnt(9, n);
        check("to_boundary", n, 9);
        send(3);
        exp_q.push_back({1'b1, 4'd0});
        to_cnt(0, n);
        check("boundary_edge", n, 1);
        run_period(1, 1, 0);
        run_period(2, 1, 0);
        run_period(3, 0, 1);

        // Reset mid-ramp abandons the ramp
        send(9);
        run_period(4, 1, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_reset_state();
        exp_q.push_back({1'b0, 4'd5});
        rst = 1'b0;
        run_period(5, 0, 0);

`ifdef PWM_FAULT_EN
        send(9);
        run_period(6, 1, 0);
        tick();
        tick();
        mon_en = 1'b0;
        fault = 1'b1;
        tick();
        fault = 1'b0;
        check("fault_duty", 32'(duty_out), 0);
        check("fault_ready", 32'(cmd_ready), 0);
        check("fault_busy", 32'(busy), 0);
        check("fault_state", 32'(state), 32'(FAULT));
        cmd_duty  = 4'd7;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        cmd_valid = 1'b0;
        check("fault_ignores_cmd", 32'(duty_out), 0);
        check("fault_held", 32'(state), 32'(FAULT));
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_state", 32'(state), 32'(IDLE));
        check("clr_ready", 32'(cmd_ready), 1);
        check("clr_busy", 32'(busy), 0);
        for (int i = 0; i < 12; i++) tick();
        check("clr_duty", 32'(duty_out), 0);
`endif

        tick();
        tick();
        tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
